// File: rtl/mult4_pkg.sv
// ============================================================================
// Module   : mult4_pkg
// Purpose  : Shared state encoding and sizing constants for the mult4 core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult4_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must hold 0..WIDTH inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult4_seq_core_if.sv
// ============================================================================
// Module   : mult4_seq_core_if
// Purpose  : Operand/start request and product/status bundle of the core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult4_seq_core_if
  import mult4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;

  modport master (output start, a, b, input product, busy, done);
  modport slave  (input start, a, b, output product, busy, done);
endinterface

`default_nettype wire

// File: rtl/mult4_edge_det.sv
// ============================================================================
// Module   : mult4_edge_det
// Purpose  : Registered rising-edge detector with clock enable; history resets
//            high so a level already high out of reset is not seen as an edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult4_edge_det (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  ena,
  input  wire  d,
  output logic pulse
);

  logic hist_q, hist_d;
  logic pulse_q, pulse_d;

  always_comb begin
    hist_d  = d;
    pulse_d = d & ~hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else if (ena) begin
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/mult4_seq_core.sv
// ============================================================================
// Module   : mult4_seq_core
// Purpose  : Iterative shift-and-add unsigned multiplier, one multiplier bit
//            per enabled clock; product register only updates on completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult4_seq_core
  import mult4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               ena,
  mult4_seq_core_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  logic             start_pulse;
  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    acc_next;

  mult4_edge_det u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (bus.start),
    .pulse (start_pulse)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    count_d   = count_q;
    acc_next  = acc_q + (mplier_q[0] ? (mcand_q << count_q) : '0);

    case (state_q)
      IDLE, DONE: begin
        if (start_pulse) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        // Final bit: publish the completed sum in the same edge.
        if (count_q == CNT_W'(WIDTH - 1)) begin
          product_d = acc_next;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == CALC);
  assign bus.done    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mult4_seq_core.sv
// ============================================================================
// Module   : tb_mult4_seq_core
// Purpose  : Self-checking bench for mult4_seq_core against a plain a*b model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult4_seq_core;
  import mult4_pkg::*;

  localparam int W   = 4;
  // Negedges from the one following the start-sampling edge until done shows.
  localparam int LAT = W + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;

  mult4_seq_core_if #(.WIDTH(W)) bus ();

  mult4_seq_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int a;
    int b;
    int exp_p;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issue one multiply and wait (bounded) for done after a busy phase.
  task automatic run_mult(input int a, input int b, output int prod,
                          output int lat, output int busy_cyc, output int stable);
    int  prev;
    bit  seen_busy;
    bus.start = 1'b0;
    step();
    bus.a     = a[W-1:0];
    bus.b     = b[W-1:0];
    bus.start = 1'b1;
    prev      = int'(bus.product);
    lat       = 0;
    busy_cyc  = 0;
    stable    = 1;
    seen_busy = 1'b0;
    while (lat < 40) begin
      step();
      lat++;
      if (bus.busy) begin
        busy_cyc++;
        seen_busy = 1'b1;
      end
      if (seen_busy && bus.done) break;
      if (int'(bus.product) != prev) stable = 0;
    end
    prod = int'(bus.product);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prod, lat, busy_cyc, stable, cnt, ra, rb;

    vecs[0] = '{3, 5, 15};
    vecs[1] = '{15, 15, 225};
    vecs[2] = '{0, 9, 0};
    vecs[3] = '{9, 0, 0};
    vecs[4] = '{1, 15, 15};
    vecs[5] = '{10, 13, 130};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    check("reset_product", int'(bus.product), 0);
    check("reset_busy",    int'(bus.busy),    0);
    check("reset_done",    int'(bus.done),    0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_mult(vecs[i].a, vecs[i].b, prod, lat, busy_cyc, stable);
      check($sformatf("vec%0d_product", i), prod, vecs[i].exp_p);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_busy_cycles", i), busy_cyc, W);
      check($sformatf("vec%0d_no_partial", i), stable, 1);
      check($sformatf("vec%0d_done", i), int'(bus.done), 1);
    end

    // Start held high after 15*15 must not launch a second run.
    run_mult(15, 15, prod, lat, busy_cyc, stable);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy) cnt++;
    end
    check("hold_no_rerun_busy", cnt, 0);
    check("hold_done",          int'(bus.done), 1);
    check("hold_product",       int'(bus.product), 225);

    // Second edge and operand change during 6*7 are ignored.
    bus.start = 1'b0;
    step();
    bus.a = 4'd6; bus.b = 4'd7; bus.start = 1'b1;
    step();
    step();
    check("restart_busy_seen", int'(bus.busy), 1);
    bus.start = 1'b0;
    step();
    bus.a = 4'd1; bus.b = 4'd1; bus.start = 1'b1;
    cnt = 0;
    while (!bus.done && cnt < 20) begin
      step();
      cnt++;
    end
    check("restart_done",    int'(bus.done),    1);
    check("restart_product", int'(bus.product), 42);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.busy) cnt++;
    end
    check("restart_not_queued", cnt, 0);

    // Asynchronous reset mid-run clears everything at once.
    bus.start = 1'b0;
    step();
    bus.a = 4'd13; bus.b = 4'd11; bus.start = 1'b1;
    step();
    step();
    check("rst_mid_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_product", int'(bus.product), 0);
    check("rst_mid_busy",    int'(bus.busy),    0);
    check("rst_mid_done",    int'(bus.done),    0);
    step();
    rst_n = 1'b1;
    run_mult(5, 5, prod, lat, busy_cyc, stable);
    check("post_rst_product", prod, 25);
    check("post_rst_latency", lat, LAT);

    // Clock-enable low for 3 cycles stretches the run by exactly 3 cycles.
    bus.start = 1'b0;
    step();
    bus.a = 4'd12; bus.b = 4'd11; bus.start = 1'b1;
    step();
    step();
    lat = 2;
    ena = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      lat++;
      if (bus.busy && !bus.done) cnt++;
    end
    check("ena_frozen_busy", cnt, 3);
    ena = 1'b1;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
    check("ena_latency", lat, LAT + 3);
    check("ena_product", int'(bus.product), 132);

    // Random operands against the arithmetic model.
    for (int t = 0; t < 20; t++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      run_mult(ra, rb, prod, lat, busy_cyc, stable);
      check($sformatf("rand%0d_%0dx%0d", t, ra, rb), prod, ra * rb);
      check($sformatf("rand%0d_latency", t), lat, LAT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
